cache_fill_arbiter: RTL and testbench
=====================================

CACHE_FILL_ARBITER -- requirements
Module: cache_fill_arbiter

Interface
Parameters:
REQ-001 SHALL have parameter BLOCK_WORDS, default 8: 16-bit words per cache block (16-byte block).
REQ-002 SHALL have parameter MEM_LATENCY, default 4: cycles from mem_en to mem_data_valid for a read.
Ports (name, direction, width, meaning):
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have ports i_miss, d_miss, input, 1 each: level miss requests, held high until the matching done pulse.
REQ-006 SHALL have ports i_miss_addr, d_miss_addr, input, 16 each: miss byte addresses.
REQ-007 SHALL have ports d_store_req (input, 1), d_store_addr (input, 16), d_store_data (input, 16): write-through store request.
REQ-008 SHALL have port d_store_ack, output, 1: store accepted this cycle.
REQ-009 SHALL have ports mem_en, mem_wr (output, 1 each), mem_addr, mem_data_in (output, 16 each): main-memory command.
REQ-010 SHALL have ports mem_data_valid (input, 1) and mem_data_out (input, 16): read return.
REQ-011 SHALL have ports fill_sel (output, 1; 0=I, 1=D), fill_wr_en (output, 1), fill_word (output, 3), fill_data (output, 16), fill_tag_wr (output, 1): cache data/tag fill port.
REQ-012 SHALL have ports i_fill_done and d_fill_done, output, 1 each: one-cycle completion pulses.

Function
REQ-013 SHALL implement FSM states IDLE, FILL, DONE.
REQ-014 In IDLE, priority SHALL be d_store_req > d_miss > i_miss.
REQ-015 In IDLE, a store SHALL drive mem_en=1, mem_wr=1, mem_addr=d_store_addr, mem_data_in=d_store_data, and d_store_ack=1 in the same cycle, remaining in IDLE.
REQ-016 d_store_ack SHALL be 0 in FILL and DONE; the requester holds the store.
REQ-017 On a miss grant, the FSM SHALL latch base=addr & 16'hFFF0 and fill_sel, then enter FILL.
REQ-018 In FILL, issue_cnt SHALL drive mem_en=1, mem_wr=0, mem_addr=base+2*issue_cnt for issue_cnt 0..7 on consecutive cycles, with no enable after the 8th issue.
REQ-019 Each mem_data_valid in FILL SHALL assert fill_wr_en with fill_word=recv_cnt and fill_data=mem_data_out, then increment recv_cnt.
REQ-020 fill_tag_wr SHALL assert together with the 8th (recv_cnt=7) word write.
REQ-021 After the 8th word, the FSM SHALL go to DONE for exactly one cycle, pulse the done output selected by fill_sel, then return to IDLE.
REQ-022 Latency from grant to the done pulse SHALL be MEM_LATENCY+BLOCK_WORDS+1 cycles (13 by default).
REQ-023 Simultaneous i_miss and d_miss SHALL serve D first; I is granted on the IDLE cycle following D's DONE.
REQ-024 A miss arriving during FILL SHALL wait; requests are never dropped.
REQ-025 mem_data_valid SHALL be ignored in IDLE and DONE.
REQ-026 Counters SHALL be 3-bit plus a terminal flag; no wrap-around into a second issue pass.
REQ-027 Address arithmetic SHALL be 16-bit modulo; base 16'hFFF0 issues up to 16'hFFFE.

Reset
REQ-028 On rst, the FSM SHALL enter IDLE, clear issue_cnt, recv_cnt, base and fill_sel, and drive all outputs to 0.
REQ-029 Reset during FILL SHALL abandon the fill with no done pulse, no further fill_wr_en, and in-flight returns ignored.

Structure
REQ-030 State encodings, BLOCK_WORDS and MEM_LATENCY defaults SHALL live in the shared cpu package.
REQ-031 The FSM and counters SHALL be in one module; an optional sub-module fill_counter (3-bit count, enable, terminal flag) MAY be instantiated twice.

Verification
REQ-032 i_miss addr 16'h0124 with memory returning addr value -> reads at 16'h0120..16'h012E, words 0..7 written, tag_wr with word 7, i_fill_done 13 cycles after grant.
REQ-033 i_miss and d_miss high in the same cycle (d addr 16'h8006) -> D fill of 16'h8000 block completes first, then I fill starts the next IDLE cycle.
REQ-034 d_store_req and d_miss in the same IDLE cycle -> store written (mem_wr=1, ack=1) that cycle; D fill is granted the following cycle.
REQ-035 d_store_req raised mid-FILL -> ack held at 0 until IDLE, then a single write is performed.
REQ-036 rst asserted at word 3 of a fill -> no done pulse, all outputs 0 next cycle, and a late mem_data_valid causes no fill_wr_en.
REQ-037 Miss at 16'hFFFA -> addresses 16'hFFF0..16'hFFFE, no wrap to 16'h0000.

Source files
------------

// File: rtl/cache_fill_arbiter_pkg.sv
// Shared definitions for the cache fill arbiter: FSM encoding, block geometry
// defaults and the block word address helper.
package cache_fill_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FILL = 2'd1,
    ST_DONE = 2'd2
  } fill_state_e;

  localparam int          BLOCK_WORDS_DEF = 8;
  localparam int          MEM_LATENCY_DEF = 4;
  localparam int          CNT_W           = 3;
  localparam logic [15:0] BLOCK_MASK      = 16'hFFF0;

  // Byte address of 16-bit word idx inside the block at base (16-bit modulo).
  function automatic logic [15:0] word_addr(input logic [15:0]      base,
                                            input logic [CNT_W-1:0] idx);
    return base + {{(16 - CNT_W - 1){1'b0}}, idx, 1'b0};
  endfunction

endpackage

// File: rtl/cache_fill_arbiter_fill_counter.sv
// Word counter for one fill pass: counts enabled cycles up to LAST, then sets
// a sticky terminal flag instead of wrapping.
module fill_counter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int LAST = BLOCK_WORDS_DEF - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             term_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             term_q;

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q  <= '0;
      term_q <= 1'b0;
    end else if (en_i && !term_q) begin
      if (cnt_q == CNT_W'(LAST)) begin
        term_q <= 1'b1;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign cnt_o  = cnt_q;
  assign term_o = term_q;

endmodule

// File: rtl/cache_fill_arbiter.sv
// Arbitrates I/D cache misses and write-through stores onto one memory port,
// streaming each returned block into the selected cache's fill port.
module cache_fill_arbiter
  import cache_fill_arbiter_pkg::*;
#(
  parameter int BLOCK_WORDS = BLOCK_WORDS_DEF,
  parameter int MEM_LATENCY = MEM_LATENCY_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_miss,
  input  logic        d_miss,
  input  logic [15:0] i_miss_addr,
  input  logic [15:0] d_miss_addr,
  input  logic        d_store_req,
  input  logic [15:0] d_store_addr,
  input  logic [15:0] d_store_data,
  output logic        d_store_ack,
  output logic        mem_en,
  output logic        mem_wr,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data_in,
  input  logic        mem_data_valid,
  input  logic [15:0] mem_data_out,
  output logic        fill_sel,
  output logic        fill_wr_en,
  output logic [2:0]  fill_word,
  output logic [15:0] fill_data,
  output logic        fill_tag_wr,
  output logic        i_fill_done,
  output logic        d_fill_done
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(BLOCK_WORDS - 1);

  if (BLOCK_WORDS != (1 << CNT_W) || MEM_LATENCY < 1) begin : g_param_chk
    $error("cache_fill_arbiter: BLOCK_WORDS must be 8 and MEM_LATENCY >= 1");
  end

  fill_state_e      state_q;
  logic [15:0]      base_q;
  logic             sel_q;
  logic [CNT_W-1:0] issue_cnt;
  logic [CNT_W-1:0] recv_cnt;
  logic             issue_term;
  logic             recv_term;
  logic             in_idle;
  logic             in_fill;
  logic             in_done;
  logic             store_take;
  logic             issue_en;
  logic             recv_take;
  logic             recv_last;
  logic             cnt_clr;

  assign in_idle = (state_q == ST_IDLE);
  assign in_fill = (state_q == ST_FILL);
  assign in_done = (state_q == ST_DONE);

  // Everything below is gated by rst so a reset cycle drives all outputs low,
  // even while the state register still holds FILL.
  assign store_take = !rst && in_idle && d_store_req;
  assign issue_en   = !rst && in_fill && !issue_term;
  assign recv_take  = !rst && in_fill && mem_data_valid && !recv_term;
  assign recv_last  = (recv_cnt == LAST_WORD);
  assign cnt_clr    = !in_fill;

  fill_counter #(.LAST(BLOCK_WORDS - 1)) u_issue_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (issue_en),
    .cnt_o  (issue_cnt),
    .term_o (issue_term)
  );

  fill_counter #(.LAST(BLOCK_WORDS - 1)) u_recv_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (cnt_clr),
    .en_i   (recv_take),
    .cnt_o  (recv_cnt),
    .term_o (recv_term)
  );

  // Stores win in IDLE without leaving it; a pending miss is granted once the
  // store requester goes quiet.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      sel_q   <= 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!d_store_req) begin
            if (d_miss) begin
              base_q  <= d_miss_addr & BLOCK_MASK;
              sel_q   <= 1'b1;
              state_q <= ST_FILL;
            end else if (i_miss) begin
              base_q  <= i_miss_addr & BLOCK_MASK;
              sel_q   <= 1'b0;
              state_q <= ST_FILL;
            end
          end
        end
        ST_FILL: begin
          if (recv_take && recv_last) state_q <= ST_DONE;
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign d_store_ack = store_take;
  assign mem_en      = store_take || issue_en;
  assign mem_wr      = store_take;
  assign mem_addr    = store_take ? d_store_addr :
                       (issue_en ? word_addr(base_q, issue_cnt) : 16'h0000);
  assign mem_data_in = store_take ? d_store_data : 16'h0000;

  assign fill_sel    = sel_q && !rst;
  assign fill_wr_en  = recv_take;
  assign fill_word   = recv_take ? recv_cnt : '0;
  assign fill_data   = recv_take ? mem_data_out : 16'h0000;
  assign fill_tag_wr = recv_take && recv_last;

  assign i_fill_done = !rst && in_done && !sel_q;
  assign d_fill_done = !rst && in_done && sel_q;

endmodule

// File: tb/tb_cache_fill_arbiter.sv
// Bench for cache_fill_arbiter: directed scenarios followed by random traffic,
// checked each cycle against a timeline model of grants, reads, fills and done.
module tb_cache_fill_arbiter;

  localparam int BW     = 8;
  localparam int LAT    = 4;
  localparam int DONE_K = LAT + BW + 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_miss, d_miss;
  logic [15:0] i_miss_addr, d_miss_addr;
  logic        d_store_req;
  logic [15:0] d_store_addr, d_store_data;
  logic        d_store_ack;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_data_in;
  logic        mem_data_valid;
  logic [15:0] mem_data_out;
  logic        fill_sel, fill_wr_en;
  logic [2:0]  fill_word;
  logic [15:0] fill_data;
  logic        fill_tag_wr;
  logic        i_fill_done, d_fill_done;

  always #5 clk = ~clk;

  cache_fill_arbiter #(.BLOCK_WORDS(BW), .MEM_LATENCY(LAT)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_miss         (i_miss),
    .d_miss         (d_miss),
    .i_miss_addr    (i_miss_addr),
    .d_miss_addr    (d_miss_addr),
    .d_store_req    (d_store_req),
    .d_store_addr   (d_store_addr),
    .d_store_data   (d_store_data),
    .d_store_ack    (d_store_ack),
    .mem_en         (mem_en),
    .mem_wr         (mem_wr),
    .mem_addr       (mem_addr),
    .mem_data_in    (mem_data_in),
    .mem_data_valid (mem_data_valid),
    .mem_data_out   (mem_data_out),
    .fill_sel       (fill_sel),
    .fill_wr_en     (fill_wr_en),
    .fill_word      (fill_word),
    .fill_data      (fill_data),
    .fill_tag_wr    (fill_tag_wr),
    .i_fill_done    (i_fill_done),
    .d_fill_done    (d_fill_done)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          rv [0:255];
  logic [15:0] rd [0:255];
  logic [15:0] salt = 16'h0000;
  bit          spur_en = 1'b0;
  bit          strict_zero = 1'b0;

  // Model: at most one block fill in flight, described by its grant cycle.
  bit          m_active = 1'b0;
  int          m_g = 0;
  logic [15:0] m_base = 16'h0;
  bit          m_sel = 1'b0;
  bit          m_selreg = 1'b0;
  bit          drop_st, drop_d, drop_i;
  int          fwr_cnt = 0;
  int          ack_cnt = 0;
  int          done_cyc = -1;
  int          grant_cyc = 0;

  function automatic logic [15:0] memval(input logic [15:0] a);
    return a ^ salt;
  endfunction

  function automatic bit quiet();
    return !m_active || (cyc - m_g) >= DONE_K;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_mem_en"},  mem_en, 0);
    chk({tag, "_mem_wr"},  mem_wr, 0);
    chk({tag, "_addr"},    mem_addr, 0);
    chk({tag, "_din"},     mem_data_in, 0);
    chk({tag, "_ack"},     d_store_ack, 0);
    chk({tag, "_sel"},     fill_sel, 0);
    chk({tag, "_fwr"},     fill_wr_en, 0);
    chk({tag, "_fword"},   fill_word, 0);
    chk({tag, "_fdata"},   fill_data, 0);
    chk({tag, "_tag"},     fill_tag_wr, 0);
    chk({tag, "_idone"},   i_fill_done, 0);
    chk({tag, "_ddone"},   d_fill_done, 0);
  endtask

  task automatic model_check();
    bit          e_en, e_wr, e_ack, e_fwr, e_tag, e_id, e_dd, e_sel;
    logic [15:0] e_addr, e_din, e_fdata;
    logic [2:0]  e_word;
    int          k;
    e_en = 0; e_wr = 0; e_ack = 0; e_fwr = 0; e_tag = 0; e_id = 0; e_dd = 0;
    e_addr = 0; e_din = 0; e_fdata = 0; e_word = 0;
    drop_st = 0; drop_d = 0; drop_i = 0;

    if (fill_wr_en === 1'b1) fwr_cnt++;
    if (d_store_ack === 1'b1) ack_cnt++;
    if (i_fill_done === 1'b1 || d_fill_done === 1'b1) done_cyc = cyc;
    if (mem_en === 1'b1 && mem_wr === 1'b0) begin
      rv[(cyc + LAT) % 256] = 1'b1;
      rd[(cyc + LAT) % 256] = memval(mem_addr);
    end

    if (rst || strict_zero) begin
      check_zero(rst ? "rst" : "post_rst");
      if (rst) begin
        m_active = 0;
        m_selreg = 0;
      end
      strict_zero = 0;
      return;
    end

    e_sel = m_selreg;
    if (m_active && (cyc - m_g) > DONE_K) m_active = 0;
    if (!m_active) begin
      if (d_store_req) begin
        e_en = 1; e_wr = 1; e_ack = 1;
        e_addr = d_store_addr; e_din = d_store_data;
        drop_st = 1;
      end else if (d_miss || i_miss) begin
        m_active = 1;
        m_g = cyc;
        grant_cyc = cyc;
        m_sel = d_miss;
        m_base = (d_miss ? d_miss_addr : i_miss_addr) & 16'hFFF0;
        m_selreg = m_sel;
      end
    end else begin
      k = cyc - m_g;
      if (k >= 1 && k <= BW) begin
        e_en = 1;
        e_addr = m_base + 16'(2 * (k - 1));
      end
      if (k > LAT && k <= LAT + BW) begin
        e_fwr = 1;
        e_word = 3'(k - LAT - 1);
        e_fdata = memval(m_base + 16'(2 * (k - LAT - 1)));
        e_tag = (k == LAT + BW);
      end
      if (k == DONE_K) begin
        e_id = !m_sel; e_dd = m_sel;
        drop_i = !m_sel; drop_d = m_sel;
      end
    end

    chk("mem_en", mem_en, e_en);
    chk("mem_wr", mem_wr, e_wr);
    chk("store_ack", d_store_ack, e_ack);
    chk("fill_wr_en", fill_wr_en, e_fwr);
    chk("fill_tag_wr", fill_tag_wr, e_tag);
    chk("i_fill_done", i_fill_done, e_id);
    chk("d_fill_done", d_fill_done, e_dd);
    chk("fill_sel", fill_sel, e_sel);
    if (e_en) chk("mem_addr", mem_addr, e_addr);
    if (e_wr) chk("mem_data_in", mem_data_in, e_din);
    if (e_fwr) begin
      chk("fill_word", fill_word, e_word);
      chk("fill_data", fill_data, e_fdata);
    end
  endtask

  // Entered at posedge+1 with this cycle's requests already applied.
  task automatic cycle();
    int slot;
    slot = cyc % 256;
    mem_data_valid = rv[slot];
    mem_data_out   = rv[slot] ? rd[slot] : 16'h0000;
    rv[slot] = 1'b0;
    if (spur_en && !mem_data_valid && quiet() && $urandom_range(0, 3) == 0) begin
      mem_data_valid = 1'b1;
      mem_data_out   = 16'($urandom);
    end
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
    cyc++;
    mem_data_valid = 1'b0;
    if (drop_st) d_store_req = 1'b0;
    if (drop_d)  d_miss = 1'b0;
    if (drop_i)  i_miss = 1'b0;
  endtask

  task automatic run_until_idle(input int max_cyc, input string tag);
    bit ok;
    ok = 0;
    for (int n = 0; n < max_cyc; n++) begin
      if (!i_miss && !d_miss && !d_store_req && (!m_active || (cyc - m_g) > DONE_K)) begin
        ok = 1;
        break;
      end
      cycle();
    end
    chk({tag, "_timeout"}, ok, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    i_miss = 0; d_miss = 0; i_miss_addr = 0; d_miss_addr = 0;
    d_store_req = 0; d_store_addr = 0; d_store_data = 0;
    mem_data_valid = 0; mem_data_out = 0;
    @(posedge clk);
    #1;
    cycle();
    cycle();
    rst = 1'b0;
    strict_zero = 1'b1;
    cycle();

    // I miss, memory returns the address; 13 cycles grant to done
    fwr_cnt = 0; done_cyc = -1;
    i_miss = 1; i_miss_addr = 16'h0124;
    run_until_idle(40, "i_fill");
    chk("i_fill_words", fwr_cnt, 8);
    chk("i_done_latency", done_cyc - grant_cyc, 13);

    // Simultaneous misses: D block first, then I
    fwr_cnt = 0;
    i_miss = 1; i_miss_addr = 16'h0340;
    d_miss = 1; d_miss_addr = 16'h8006;
    run_until_idle(60, "dual_miss");
    chk("dual_words", fwr_cnt, 16);

    // Store and D miss together: store first, fill next cycle
    ack_cnt = 0;
    d_store_req = 1; d_store_addr = 16'h1234; d_store_data = 16'hBEEF;
    d_miss = 1; d_miss_addr = 16'h4442;
    run_until_idle(40, "store_miss");
    chk("store_miss_acks", ack_cnt, 1);

    // Store raised mid-fill waits for IDLE
    ack_cnt = 0;
    i_miss = 1; i_miss_addr = 16'h0A0A;
    for (int n = 0; n < 4; n++) cycle();
    d_store_req = 1; d_store_addr = 16'h2222; d_store_data = 16'h5555;
    run_until_idle(40, "store_mid");
    chk("store_mid_acks", ack_cnt, 1);

    // Reset at word 3: no done, late returns ignored
    fwr_cnt = 0; done_cyc = -1;
    i_miss = 1; i_miss_addr = 16'h0200;
    for (int n = 0; n < 9; n++) cycle();
    rst = 1'b1; i_miss = 0;
    cycle();
    rst = 1'b0;
    strict_zero = 1'b1;
    cycle();
    for (int n = 0; n < 6; n++) cycle();
    chk("rst_words", fwr_cnt, 4);
    chk("rst_no_done", done_cyc, -1);

    // Top-of-memory block, no wrap
    fwr_cnt = 0;
    d_miss = 1; d_miss_addr = 16'hFFFA;
    run_until_idle(40, "top_block");
    chk("top_words", fwr_cnt, 8);

    // Random traffic with spurious returns outside the fill window
    salt = 16'($urandom);
    spur_en = 1'b1;
    for (int n = 0; n < 1500; n++) begin
      if (!i_miss && $urandom_range(0, 9) == 0) begin
        i_miss = 1; i_miss_addr = 16'($urandom);
      end
      if (!d_miss && $urandom_range(0, 9) == 0) begin
        d_miss = 1; d_miss_addr = 16'($urandom);
      end
      if (!d_store_req && $urandom_range(0, 5) == 0) begin
        d_store_req = 1; d_store_addr = 16'($urandom); d_store_data = 16'($urandom);
      end
      cycle();
    end
    spur_en = 1'b0;
    run_until_idle(100, "rand_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
